// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the two-digit 7-segment display arbiter.
package seg_disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   // 1 s hold and 100 ms blank at 25 MHz
   localparam int unsigned DEF_HOLD_CYCLES  = 25_000_000;
   localparam int unsigned DEF_BLANK_CYCLES = 2_500_000;

   localparam int unsigned HI_MSB = 7;
   localparam int unsigned HI_LSB = 4;
   localparam int unsigned LO_MSB = 3;
   localparam int unsigned LO_LSB = 0;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_Ptr (wrapping) wins.
module seg_rr_pick
   import seg_disp_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_Req,
   input  logic [IDX_W-1:0]   i_Ptr,
   output logic [NUM_REQ-1:0] o_Onehot,
   output logic               o_Valid,
   output logic [IDX_W-1:0]   o_Idx
);

   logic [IDX_W-1:0] w_Cand;

   always_comb begin
      o_Onehot = '0;
      o_Valid  = 1'b0;
      o_Idx    = '0;
      w_Cand   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_Cand = IDX_W'((32'(i_Ptr) + k) % NUM_REQ);
         if (!o_Valid && i_Req[w_Cand]) begin
            o_Onehot[w_Cand] = 1'b1;
            o_Valid          = 1'b1;
            o_Idx            = w_Cand;
         end
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the two-digit display with minimum hold and blank gap between owners.
module seg_display_arbiter
   import seg_disp_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic                      i_Clk,
   input  logic                      i_Rst_L,
   input  logic [NUM_REQ-1:0]        i_Req,
   input  logic [NUM_REQ*DATA_W-1:0] i_Data,
   output logic [NUM_REQ-1:0]        o_Grant,
   output logic [3:0]                o_Digit_Hi,
   output logic [3:0]                o_Digit_Lo,
   output logic                      o_Blank,
   output logic                      o_Busy
);

   localparam int unsigned MAX_CYC = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC);
   localparam int unsigned IDX_W   = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   state_t               r_State;
   logic [CNT_W-1:0]     r_Cnt;
   logic [IDX_W-1:0]     r_Ptr;
   logic [NUM_REQ-1:0]   r_Grant;
   logic [3:0]           r_Hi;
   logic [3:0]           r_Lo;
   logic                 r_Blank;
   logic                 r_Busy;

   logic [NUM_REQ-1:0]   w_Pick_Onehot;
   logic                 w_Pick_Valid;
   logic [IDX_W-1:0]     w_Pick_Idx;
   logic                 w_Owner_Req;
   logic                 w_Others;
   logic [DATA_W-1:0]    w_Owner_Byte;
   logic [DATA_W-1:0]    w_Pick_Byte;

   seg_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .i_Req    (i_Req),
      .i_Ptr    (r_Ptr),
      .o_Onehot (w_Pick_Onehot),
      .o_Valid  (w_Pick_Valid),
      .o_Idx    (w_Pick_Idx)
   );

   // The pointer always equals the current owner while in SHOW
   assign w_Owner_Req  = |(i_Req & r_Grant);
   assign w_Others     = |(i_Req & ~r_Grant);
   assign w_Owner_Byte = i_Data[32'(r_Ptr) * DATA_W +: DATA_W];
   assign w_Pick_Byte  = i_Data[32'(w_Pick_Idx) * DATA_W +: DATA_W];

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State <= ST_IDLE;
         r_Cnt   <= '0;
         r_Ptr   <= IDX_W'(NUM_REQ - 1);
         r_Grant <= '0;
         r_Hi    <= '0;
         r_Lo    <= '0;
         r_Blank <= 1'b1;
         r_Busy  <= 1'b0;
      end else begin
         case (r_State)
            ST_IDLE: begin
               if (w_Pick_Valid) begin
                  r_State <= ST_SHOW;
                  r_Cnt   <= '0;
                  r_Ptr   <= w_Pick_Idx;
                  r_Grant <= w_Pick_Onehot;
                  r_Hi    <= w_Pick_Byte[HI_MSB:HI_LSB];
                  r_Lo    <= w_Pick_Byte[LO_MSB:LO_LSB];
                  r_Blank <= 1'b0;
                  r_Busy  <= 1'b1;
               end
            end
            ST_SHOW: begin
               if (!w_Owner_Req || (r_Cnt == HOLD_LAST && w_Others)) begin
                  r_State <= w_Others ? ST_BLANK : ST_IDLE;
                  r_Busy  <= w_Others;
                  r_Cnt   <= '0;
                  r_Grant <= '0;
                  r_Blank <= 1'b1;
               end else begin
                  r_Hi  <= w_Owner_Byte[HI_MSB:HI_LSB];
                  r_Lo  <= w_Owner_Byte[LO_MSB:LO_LSB];
                  r_Cnt <= (r_Cnt == HOLD_LAST) ? '0 : r_Cnt + CNT_W'(1);
               end
            end
            ST_BLANK: begin
               if (r_Cnt == BLANK_LAST) begin
                  r_Cnt <= '0;
                  if (w_Pick_Valid) begin
                     r_State <= ST_SHOW;
                     r_Ptr   <= w_Pick_Idx;
                     r_Grant <= w_Pick_Onehot;
                     r_Hi    <= w_Pick_Byte[HI_MSB:HI_LSB];
                     r_Lo    <= w_Pick_Byte[LO_MSB:LO_LSB];
                     r_Blank <= 1'b0;
                  end else begin
                     r_State <= ST_IDLE;
                     r_Busy  <= 1'b0;
                  end
               end else begin
                  r_Cnt <= r_Cnt + CNT_W'(1);
               end
            end
            default: begin
               r_State <= ST_IDLE;
               r_Cnt   <= '0;
               r_Grant <= '0;
               r_Blank <= 1'b1;
               r_Busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_Grant    = r_Grant;
   assign o_Digit_Hi = r_Hi;
   assign o_Digit_Lo = r_Lo;
   assign o_Blank    = r_Blank;
   assign o_Busy     = r_Busy;

   a_grant_onehot0: assert property (@(posedge i_Clk) disable iff (!i_Rst_L) $onehot0(r_Grant));

endmodule
